muldiv_unit: RTL

- Parametrised multicycle multiply/divide unit. It replaces the separate multiplier and divisor blocks in the datapath with one shared engine.
- Produces a HI/LO result pair in MIPS convention: mult gives HI:LO = product; div gives LO = quotient, HI = remainder.
- Adds signed/unsigned modes, abort, back-to-back issue and a WIDTH parameter.
- The control FSM drives start/op and waits for done before writing the HI/LO registers.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Shared multicycle multiply/divide engine producing a MIPS-style HI/LO pair.
// Latency: done in cycle WIDTH+2 after accept; cycle 1 for divide by zero.
// No backpressure: start is taken only in IDLE/DONE and dropped while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  state_t               w_accept_next;
  logic                 w_accept;

  logic                 r_is_div;
  logic                 r_neg_q;     // quotient/product must be negated
  logic                 r_neg_r;     // remainder takes the dividend's sign
  logic [WIDTH-1:0]     r_opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;       // {partial hi / remainder, multiplier / quotient}
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_dbz;

  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  // Operand decode: signed ops work on magnitudes and fix signs at the end.
  assign w_is_div = op[1];
  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & a[WIDTH-1];
  assign w_neg_b  = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? (-a) : a;
  assign w_abs_b  = w_neg_b ? (-b) : b;
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept_next = (w_is_div && w_b_zero) ? S_DONE : S_CALC;

  // One multiply step: conditionally add multiplicand to the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift in the next dividend bit, keep the difference if no borrow.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_step = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  // Sign fix-up applied on the way into hi/lo.
  assign w_prod = r_neg_q ? (-r_acc) : r_acc;
  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_lo = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_fix_hi = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state, accept decision and status outputs.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept = 1'b1;
          w_next   = w_accept_next;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = w_accept_next;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, commit hi/lo leaving FIX.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
      r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
      r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
      r_cnt    <= '0;
      // A zero divisor goes straight to DONE, so this edge is also the flag's set edge.
      r_dbz    <= w_is_div & w_b_zero;
    end else if (r_state == S_CALC) begin
      r_acc <= r_is_div ? w_div_step : w_mul_step;
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_FIX && !abort) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
